x_pattern_source: RTL and testbench

- Upstream stimulus stage for the Activity 4 state-diagram FSM.
- Accepts a pattern word through a valid/ready handshake and serialises it, one bit per bit period, onto the FSM's single-bit input x.
- Emits a strobe marking each new bit and a done pulse after the last bit, so the downstream FSM and its checker can sample in lock-step.

---
 rtl/x_pattern_source.sv | 174 +++++++++++++++++
 tb/tb_x_pattern_source.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/x_pattern_source.sv
// Serialises a loaded pattern word onto the single-bit FSM input x, one bit per DIV-cycle period.
// Optional build macro X_SRC_MSB_FIRST_EN sends the active field MSB first (default LSB first).
module x_pattern_source #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 4,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             hold,
    output logic             x,
    output logic             x_strobe,
    output logic [LEN_W-1:0] bit_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_shift, w_shift_nxt;
    logic [LEN_W-1:0]   r_rem,   w_rem_nxt;
    logic [DIV_W-1:0]   r_div,   w_div_nxt;
    logic               r_x,     w_x_nxt;
    logic               r_strobe, w_strobe_nxt;
    logic [LEN_W-1:0]   r_idx,   w_idx_nxt;
    logic               r_busy,  w_busy_nxt;
    logic               r_done,  w_done_nxt;
    logic               r_ready, w_ready_nxt;

    logic [LEN_W-1:0]   w_len;
    logic [WIDTH-1:0]   w_load_word;
    logic               w_first_bit;
    logic [WIDTH-1:0]   w_next_word;
    logic               w_next_bit;

    // Effective length: 0 and anything above WIDTH both mean a full word
    always_comb begin
        w_len = load_len;
        if (load_len == '0 || load_len > LEN_W'(WIDTH)) begin
            w_len = LEN_W'(WIDTH);
        end
    end

`ifdef X_SRC_MSB_FIRST_EN
    // Left-align the active field so its top bit always sits at WIDTH-1
    assign w_load_word = load_data << (LEN_W'(WIDTH) - w_len);
    assign w_first_bit = w_load_word[WIDTH-1];
    assign w_next_word = r_shift << 1;
    assign w_next_bit  = r_shift[WIDTH-2];
`else
    assign w_load_word = load_data;
    assign w_first_bit = load_data[0];
    assign w_next_word = r_shift >> 1;
    assign w_next_bit  = r_shift[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_x      <= 1'b0;
            r_strobe <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_rem    <= w_rem_nxt;
            r_div    <= w_div_nxt;
            r_x      <= w_x_nxt;
            r_strobe <= w_strobe_nxt;
            r_idx    <= w_idx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_rem_nxt    = r_rem;
        w_div_nxt    = r_div;
        w_x_nxt      = r_x;
        w_strobe_nxt = 1'b0;
        w_idx_nxt    = r_idx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_ready_nxt  = r_ready;

        unique case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                w_x_nxt     = 1'b0;
                w_busy_nxt  = 1'b0;
                if (load_valid && r_ready) begin
                    w_state_nxt  = S_SHIFT;
                    w_shift_nxt  = w_load_word;
                    w_rem_nxt    = w_len;
                    w_div_nxt    = '0;
                    w_x_nxt      = w_first_bit;
                    w_strobe_nxt = 1'b1;
                    w_idx_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    w_ready_nxt  = 1'b0;
                end
            end

            S_SHIFT: begin
                w_ready_nxt = 1'b0;
                w_busy_nxt  = 1'b1;
                if (!hold) begin
                    if (r_div == DIV_W'(DIV - 1)) begin
                        if (r_rem == LEN_W'(1)) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                            w_x_nxt     = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_rem_nxt   = '0;
                            w_div_nxt   = '0;
                        end else begin
                            w_shift_nxt  = w_next_word;
                            w_rem_nxt    = r_rem - LEN_W'(1);
                            w_div_nxt    = '0;
                            w_x_nxt      = w_next_bit;
                            w_strobe_nxt = 1'b1;
                            w_idx_nxt    = r_idx + LEN_W'(1);
                        end
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_x_nxt     = 1'b0;
                w_busy_nxt  = 1'b0;
                w_ready_nxt = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
                w_x_nxt     = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign load_ready = r_ready;
    assign x          = r_x;
    assign x_strobe   = r_strobe;
    assign bit_idx    = r_idx;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_x_pattern_source.sv
// Self-checking bench for x_pattern_source: per-cycle trace compared against a bit-period model.
module tb_x_pattern_source;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIV   = 4;
    localparam int unsigned LEN_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             hold;
    logic             x;
    logic             x_strobe;
    logic [LEN_W-1:0] bit_idx;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic x;
        logic stb;
        logic busy;
        logic done;
        logic rdy;
        int   idx;
    } rec_t;

    x_pattern_source #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .hold       (hold),
        .x          (x),
        .x_strobe   (x_strobe),
        .bit_idx    (bit_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until the block offers load_ready
    task automatic wait_ready(input string name);
        int n = 0;
        while (load_ready !== 1'b1 && n < 200) begin
            next_cycle();
            n++;
        end
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_timeout load_ready=%b required=1", name, load_ready);
        end
    endtask

    // One pattern: handshake, then every following cycle checked against the model.
    // Hold is high for relative cycles [hs, hs+hn); a FFFF word is offered at relative cycle vp.
    task automatic run_txn(input logic [WIDTH-1:0] data, input int len, input int hs,
                           input int hn, input int vp, input string name);
        int   eff;
        logic bits[$];
        rec_t exp[$];
        int   c;
        int   cnt;
        logic h;
        eff = (len == 0 || len > int'(WIDTH)) ? int'(WIDTH) : len;
        for (int k = 0; k < eff; k++) begin
`ifdef X_SRC_MSB_FIRST_EN
            bits.push_back(data[eff-1-k]);
`else
            bits.push_back(data[k]);
`endif
        end
        // Each bit lasts until DIV unheld cycles have elapsed in its period
        c = 1;
        for (int k = 0; k < eff; k++) begin
            cnt = 0;
            while (cnt < int'(DIV)) begin
                h = (c >= hs && c < hs + hn);
                exp.push_back('{x: bits[k], stb: (cnt == 0 && exp.size() >= 0 && (k == 0 ? c == 1 : 1'b1) && (cnt == 0)), busy: 1'b1, done: 1'b0, rdy: 1'b0, idx: k});
                if (!h) cnt++;
                c++;
            end
        end
        // strobe only on the first cycle of each period, even if that cycle is held
        for (int i = 1; i < exp.size(); i++) begin
            if (exp[i].idx == exp[i-1].idx) exp[i].stb = 1'b0;
        end
        exp.push_back('{x: 1'b0, stb: 1'b0, busy: 1'b0, done: 1'b1, rdy: 1'b0, idx: -1});
        exp.push_back('{x: 1'b0, stb: 1'b0, busy: 1'b0, done: 1'b0, rdy: 1'b1, idx: -1});
        for (int i = 0; i < 3; i++)
            exp.push_back('{x: 1'b0, stb: 1'b0, busy: 1'b0, done: 1'b0, rdy: 1'b1, idx: -1});

        wait_ready(name);
        load_valid = 1'b1;
        load_data  = data;
        load_len   = LEN_W'(len);
        hold       = 1'b0;
        next_cycle();
        load_valid = 1'b0;
        for (int i = 0; i < exp.size(); i++) begin
            c = i + 1;
            checks++;
            if (x !== exp[i].x || x_strobe !== exp[i].stb || busy !== exp[i].busy ||
                done !== exp[i].done || load_ready !== exp[i].rdy) begin
                failures++;
                $display("FAIL %s cyc=t+%0d x/stb/busy/done/rdy=%b%b%b%b%b required=%b%b%b%b%b",
                         name, c, x, x_strobe, busy, done, load_ready,
                         exp[i].x, exp[i].stb, exp[i].busy, exp[i].done, exp[i].rdy);
            end
            if (exp[i].idx >= 0) begin
                checks++;
                if (bit_idx !== LEN_W'(exp[i].idx)) begin
                    failures++;
                    $display("FAIL %s_idx cyc=t+%0d bit_idx=%0d required=%0d", name, c, bit_idx, exp[i].idx);
                end
            end
            hold = (c >= hs && c < hs + hn) ? 1'b1 : ($urandom_range(0, 3) == 0 && exp[i].busy == 1'b0);
            if (c == vp) begin
                load_valid = 1'b1;
                load_data  = '1;
                load_len   = '0;
            end else begin
                load_valid = 1'b0;
            end
            next_cycle();
        end
        hold = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        hold       = 1'b0;
        #3;
        checks++;
        if (x !== 1'b0 || x_strobe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            load_ready !== 1'b1 || bit_idx !== '0) begin
            failures++;
            $display("FAIL reset x/stb/busy/done/rdy=%b%b%b%b%b idx=%0d required=00001 idx=0",
                     x, x_strobe, busy, done, load_ready, bit_idx);
        end
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic();
        run_txn(16'h000B, 4, 0, 0, 0, "basic_len4");
        run_txn(16'hA5A5, 0, 0, 0, 0, "len0_full");
        run_txn(16'h1234, 1, 0, 0, 0, "len1");
        run_txn(16'hC3C3, 31, 0, 0, 0, "len_clamp");
    endtask

    task automatic test_hold();
        run_txn(16'h000B, 4, 6, 3, 0, "hold_bit1");
        run_txn(16'h000B, 4, 1, 2, 0, "hold_first_cycle");
        run_txn(16'h0006, 3, 12, 2, 0, "hold_last_div");
    endtask

    task automatic test_load_ignored();
        run_txn(16'h000B, 4, 0, 0, 3, "valid_during_shift");
    endtask

    task automatic test_reset_mid();
        wait_ready("reset_mid");
        load_valid = 1'b1;
        load_data  = 16'h00FF;
        load_len   = LEN_W'(8);
        next_cycle();
        load_valid = 1'b0;
        for (int i = 1; i < 7; i++) next_cycle();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre busy=%b required=1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (x !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0 || x_strobe !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async x/busy/rdy/done/stb=%b%b%b%b%b required=00100",
                     x, busy, load_ready, done, x_strobe);
        end
        next_cycle();
        #2 reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_after cyc=%0d done=%b busy=%b required=0 0", i, done, busy);
            end
        end
        run_txn(16'h000B, 4, 0, 0, 0, "after_reset");
    endtask

    task automatic test_msb();
        run_txn(16'h0003, 4, 0, 0, 0, "order_0003");
    endtask

    task automatic test_random();
        int hs;
        for (int n = 0; n < 8; n++) begin
            hs = $urandom_range(1, 20);
            run_txn(16'($urandom), int'($urandom_range(0, 20)), hs, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 10)), "random");
        end
    endtask

    task automatic test_back_to_back();
        run_txn(16'h0001, 2, 0, 0, 0, "b2b_a");
        run_txn(16'h0002, 2, 0, 0, 0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_load_ignored();
        test_reset_mid();
        test_msb();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
